switch_status_debouncer: RTL
============================

Name: switch_status_debouncer

Overview:
Conditions raw greenhouse switch and relay-feedback inputs into clean status bits for the VGA status-indicator overlays.
- Per channel: 2-flop synchronizer, then a counter-based debouncer.
- Debounced state is re-latched only at frame start, so an indicator never changes mid-frame (no tearing).
- Sits directly upstream of the per-switch indicator overlays; each status bit drives one indicator's status input.

Parameters:
N_SW, 4, number of switch channels.
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal range 2..2^CNT_W-1.
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  input  1  system/pixel clock.
reset  input  1  asynchronous, active-high reset.
sw_raw  input  N_SW  raw asynchronous switch levels, 1 = on.
frame_start  input  1  single-cycle pulse from the VGA sync generator at the start of vertical blanking.
status  output  N_SW  frame-latched debounced state; feeds the indicator overlays.
status_live  output  N_SW  debounced state, updated immediately on acceptance.
change_pulse  output  N_SW  one-cycle pulse per channel when status_live changes.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: all sync flops, counters, status, status_live and change_pulse are 0. Reset mid-count discards the partial count.
- Synchronizer: sync1 <= sw_raw, then sync2 <= sync1. All further logic uses sync2 only.
- Debounce, per channel, with cnt CNT_W bits:
  - If sync2 == status_live: cnt <= 0.
  - Else, if cnt == DEBOUNCE_CYCLES-1: status_live <= sync2, cnt <= 0, change_pulse <= 1.
  - Else: cnt <= cnt + 1.
- Glitch rejection: any return to the old level before the terminal count restarts the count from 0.
- Latency: a clean edge on sw_raw reaches status_live exactly 2 + DEBOUNCE_CYCLES clk edges later.
- change_pulse is registered and high for exactly one cycle, in the same cycle status_live first shows the new value.
- Frame latch: on frame_start, status <= status_live (all channels together); otherwise status holds.
- Simultaneous events: if frame_start and an acceptance occur on the same edge, status takes the pre-update status_live. The new value appears at the next frame_start.
- Multiple frame_start pulses with no change leave status unchanged.
- Channels are fully independent. No arithmetic overflow is possible because cnt never exceeds DEBOUNCE_CYCLES-1.

Optional Feature:
Macro: SWITCH_TOGGLE_COUNT_EN.
- Defined:
  - Adds output toggle_count, width N_SW*8. Channel i occupies bits [8i+7:8i].
  - Each channel's 8-bit counter increments on that channel's change_pulse and saturates at 255 (no wrap).
  - Input clear_counts (1 bit) zeroes all counters synchronously. clear_counts has priority over a simultaneous increment.
  - Counters reset to 0.
- Undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Shared package (greenhouse display package):
  - DEBOUNCE_CYCLES_DEFAULT and CNT_W_DEFAULT constants.
  - The N_SW default, shared with the overlay layout.
  - The toggle counter width constant (8).
- One sub-module, debounce_channel: a single-bit synchronizer plus debounce counter, with outputs level and change.
- The top module generates N_SW instances of debounce_channel and owns the frame latch and the optional counters.

Test Plan:
(All with DEBOUNCE_CYCLES=4, N_SW=4.)
1. Reset: assert reset asynchronously mid-cycle with sw_raw=4'hF -> all outputs 0 immediately. After release, status_live=4'hF at exactly 6 edges.
2. Clean edge: sw_raw[0] 0->1, then hold -> status_live[0]=1 after 6 edges. change_pulse[0] is high exactly 1 cycle. status[0] stays 0 until the next frame_start, then 1.
3. Glitch: sw_raw[1] high for 3 cycles, then low -> status_live[1] never rises and change_pulse[1] never pulses. Then high for 4 cycles (after sync) -> accepted.
4. Coincidence: frame_start on the same edge status_live[2] accepts 1 -> status[2]=0. At the next frame_start, status[2]=1.
5. Independence: sw_raw = 4'b1010 applied together, channel 3 bouncing -> channel 1 accepted on time; channel 3 delayed until stable for 4 cycles.
6. With SWITCH_TOGGLE_COUNT_EN defined:
   - 300 accepted toggles on channel 0 -> toggle_count[7:0]=255.
   - clear_counts coincident with a change_pulse -> 0.

Source files
------------

// File: rtl/switch_status_debouncer_pkg.sv
// Shared greenhouse display constants: switch count, debounce timing and toggle counter width.
package switch_status_debouncer_pkg;
  localparam int N_SW_DEFAULT            = 4;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int CNT_W_DEFAULT           = 20;
  localparam int TOGGLE_W                = 8;
endpackage

// File: rtl/switch_status_debouncer_debounce_channel.sv
// One switch channel: 2-flop synchronizer followed by a stable-count debouncer.
module debounce_channel
  import switch_status_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic change_o
);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             change_q, change_d;

  always_comb begin
    cnt_d    = cnt_q;
    level_d  = level_q;
    change_d = 1'b0;
    // Any sample matching the accepted level restarts the count, so glitches never accumulate.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      level_d  = sync2_q;
      cnt_d    = '0;
      change_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      change_q <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      change_q <= change_d;
    end
  end

  assign level_o  = level_q;
  assign change_o = change_q;
endmodule

// File: rtl/switch_status_debouncer.sv
// Debounced, frame-latched switch status for the indicator overlays.
// Optional per-channel saturating toggle counters under SWITCH_TOGGLE_COUNT_EN.
module switch_status_debouncer
  import switch_status_debouncer_pkg::*;
#(
  parameter int N_SW            = N_SW_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_SW-1:0]            sw_raw,
  input  logic                       frame_start,
`ifdef SWITCH_TOGGLE_COUNT_EN
  input  logic                       clear_counts,
  output logic [N_SW*TOGGLE_W-1:0]   toggle_count,
`endif
  output logic [N_SW-1:0]            status,
  output logic [N_SW-1:0]            status_live,
  output logic [N_SW-1:0]            change_pulse
);
  logic [N_SW-1:0] status_q, status_d;

  for (genvar g = 0; g < N_SW; g++) begin : gen_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (sw_raw[g]),
      .level_o  (status_live[g]),
      .change_o (change_pulse[g])
    );
  end

  // Latching the pre-edge status_live means a same-edge acceptance waits for the next frame.
  always_comb begin
    status_d = status_q;
    if (frame_start) status_d = status_live;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) status_q <= '0;
    else       status_q <= status_d;
  end

  assign status = status_q;

`ifdef SWITCH_TOGGLE_COUNT_EN
  logic [N_SW-1:0][TOGGLE_W-1:0] tcnt_q, tcnt_d;

  always_comb begin
    tcnt_d = tcnt_q;
    for (int i = 0; i < N_SW; i++) begin
      if (clear_counts)                               tcnt_d[i] = '0;
      else if (change_pulse[i] && (tcnt_q[i] != '1)) tcnt_d[i] = tcnt_q[i] + TOGGLE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tcnt_q <= '0;
    else       tcnt_q <= tcnt_d;
  end

  assign toggle_count = tcnt_q;
`endif
endmodule
